// File: rtl/icache_bram_if.sv
// icache_bram_if: single-port BRAM access bus (enable, write enable, address, data in/out).
interface icache_bram_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 7
);
  logic                  ena;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [DATA_WIDTH-1:0] douta;
  modport master (output ena, wea, addra, dina, input douta);
  modport slave (input ena, wea, addra, dina, output douta);
endinterface

// File: rtl/icache_bram.sv
// icache_bram: single-port write-first synchronous BRAM for instruction lines and tags.
// ICACHE_BRAM_OUTREG_EN adds a second ena-gated output register (read latency 2).
module icache_bram #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input logic          clka,
  input logic          rsta,
  icache_bram_if.slave bus
);
  // Zero power-up image so unwritten tag entries read as invalid; reset never touches it.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rd_d, rd_q;
  always_ff @(posedge clka) begin
    if (bus.ena && bus.wea && !rsta) mem_q[bus.addra] <= bus.dina;
  end
  always_comb rd_d = bus.wea ? bus.dina : mem_q[bus.addra];
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) rd_q <= '0;
    else if (bus.ena) rd_q <= rd_d;
  end
`ifdef ICACHE_BRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_q;
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) out_q <= '0;
    else if (bus.ena) out_q <= rd_q;
  end
  assign bus.douta = out_q;
`else
  assign bus.douta = rd_q;
`endif
endmodule

// File: tb/tb_icache_bram.sv
// tb_icache_bram: directed scoreboard bench for the line (256-bit) and tag (20-bit) configurations.
module tb_icache_bram;
`ifdef ICACHE_BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {
    bit         chk;
    string      tag;
    logic [255:0] val;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  logic [255:0] exp_out = '0;
  logic [255:0] mm [128];
  logic [19:0]  tm [128];
  icache_bram_if #(.DATA_WIDTH(256), .ADDR_WIDTH(7)) m ();
  icache_bram_if #(.DATA_WIDTH(20), .ADDR_WIDTH(7)) t ();
  icache_bram #(.DATA_WIDTH(256), .ADDR_WIDTH(7), .DEPTH(128)) dut (.clka(clk), .rsta(rst), .bus(m));
  icache_bram #(.DATA_WIDTH(20), .ADDR_WIDTH(7), .DEPTH(128)) dut_tag (.clka(clk), .rsta(rst), .bus(t));
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input logic [255:0] obs, input logic [255:0] ex);
    n_cmp++;
    assert (obs === ex) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, ex);
    end
  endtask
  task automatic step(input bit tg, input bit en, input bit we, input int a,
                      input logic [255:0] d, input bit chk, input string tag);
    logic [255:0] obs;
    exp_t e;
    @(negedge clk);
    m.ena = tg ? 1'b0 : en;
    t.ena = tg ? en : 1'b0;
    m.wea = we; t.wea = we;
    m.addra = a[6:0]; t.addra = a[6:0];
    m.dina = d; t.dina = d[19:0];
    if (en && !rst) begin
      e.chk = chk;
      e.tag = tag;
      if (tg) begin
        e.val = {236'b0, we ? d[19:0] : tm[a]};
        if (we) tm[a] = d[19:0];
      end else begin
        e.val = we ? d : mm[a];
        if (we) mm[a] = d;
      end
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    obs = tg ? {236'b0, t.douta} : m.douta;
    if (rst) cmp(tag, obs, '0);
    else if (!en) cmp(tag, obs, exp_out);
    else if (q.size() >= LAT) begin
      e = q.pop_front();
      exp_out = e.val;
      if (e.chk) cmp(e.tag, obs, e.val);
    end
  endtask
  task automatic drain(input bit tg);
    for (int i = 0; i < LAT - 1; i++) step(tg, 1, 0, 0, '0, 0, "drain");
  endtask
  initial begin
    for (int i = 0; i < 128; i++) begin
      mm[i] = '0;
      tm[i] = '0;
    end
    m.ena = 0; m.wea = 0; m.addra = '0; m.dina = '0;
    t.ena = 0; t.wea = 0; t.addra = '0; t.dina = '0;
    #1;
    cmp("reset_douta", m.douta, '0);
    cmp("reset_douta_tag", {236'b0, t.douta}, '0);
    @(negedge clk);
    rst = 0;
    step(0, 1, 0, 10, '0, 1, "rd_unwritten");
    step(0, 1, 1, 5, {32{8'hA5}}, 1, "write_first_a5");
    step(0, 1, 0, 5, '0, 1, "rd5_a5");
    step(0, 1, 1, 0, 256'd1, 1, "wr0");
    step(0, 1, 1, 127, 256'd2, 1, "wr127");
    step(0, 1, 0, 0, '0, 1, "b2b_rd0");
    step(0, 1, 0, 127, '0, 1, "b2b_rd127");
    step(0, 1, 0, 0, '0, 1, "b2b_rd0_again");
    step(0, 0, 1, 3, 256'hFF, 1, "gated_hold");
    step(0, 1, 0, 3, '0, 1, "rd3_after_gated");
    step(0, 1, 1, 9, 256'h1234, 1, "wr9");
    step(0, 1, 0, 9, '0, 1, "rd9");
    step(0, 1, 0, 9, '0, 1, "rd9_again");
    #2;
    rst = 1;
    #1;
    cmp("rst_async", m.douta, '0);
    step(0, 1, 1, 9, 256'hDEAD, 1, "rst_hold_wr");
    q.delete();
    exp_out = '0;
    @(negedge clk);
    m.ena = 0;
    rst = 0;
    step(0, 1, 0, 9, '0, 1, "rd9_after_rst");
    drain(0);
    step(0, 1, 1, 100, 256'h55, 1, "wr100_after_rst");
    step(0, 1, 0, 100, '0, 1, "rd100");
    drain(0);
    q.delete();
    step(1, 1, 0, 20, '0, 1, "tag_unwritten");
    step(1, 1, 1, 64, 256'hFFFFF, 1, "tag_wf64");
    step(1, 1, 0, 64, '0, 1, "tag_rd64");
    step(1, 1, 0, 127, '0, 1, "tag_rd127");
    drain(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/icache_bram.md
ICACHE_BRAM -- requirements
Module: icache_bram

Interface
- REQ-001: The block SHALL expose parameter DATA_WIDTH, default 256, as the word width; 256 is used for instruction lines and 20 for tag arrays.
- REQ-002: The block SHALL expose parameter ADDR_WIDTH, default 7, as the address width.
- REQ-003: The block SHALL expose parameter DEPTH, default 128 (2**ADDR_WIDTH), as the number of words.
- REQ-004: Port clka, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005: Port rsta, input, 1 bit: reset, asynchronous and active-high.
- REQ-006: Port ena, input, 1 bit: port enable; gates both reads and writes.
- REQ-007: Port wea, input, 1 bit: write enable, qualified by ena.
- REQ-008: Port addra, input, ADDR_WIDTH bits: word address.
- REQ-009: Port dina, input, DATA_WIDTH bits: write data.
- REQ-010: Port douta, output, DATA_WIDTH bits: registered read data.

Function
- REQ-011: The array SHALL hold DEPTH words of DATA_WIDTH bits and be single-port and synchronous.
- REQ-012: On a rising clka with ena=1, wea=1 and rsta=0, mem[addra] SHALL be set to dina.
- REQ-013: Write mode SHALL be WRITE_FIRST: in a write cycle, douta SHALL become dina on the same edge.
- REQ-014: On a rising clka with ena=1 and wea=0, douta SHALL become mem[addra] (read latency 1 cycle).
- REQ-015: With ena=0, the array and douta SHALL hold their values, and wea SHALL be ignored.
- REQ-016: Consecutive cycles to different addresses SHALL each return correct data one cycle later, with no bubbles.
- REQ-017: A read of an address in the cycle after a write to it SHALL return the newly written data.
- REQ-018: addra SHALL use all ADDR_WIDTH bits with no wrap logic; address DEPTH-1 SHALL be valid.
- REQ-019: All array words SHALL be zero at time zero (simulation initial / FPGA init), so unwritten tag entries read 0.

Reset
- REQ-020: Asserting rsta SHALL force douta to 0 immediately, without waiting for a clock edge.
- REQ-021: douta SHALL be held at 0 while rsta is asserted, regardless of ena and wea.
- REQ-022: Reset SHALL NOT modify array contents.
- REQ-023: A write attempted in a cycle where rsta is high SHALL be discarded.
- REQ-024: After rsta deasserts, the first enabled edge SHALL behave normally.
- REQ-025: If rsta asserts mid-operation, only douta SHALL be affected; contents written earlier SHALL survive.

Configuration
- REQ-026: Macro ICACHE_BRAM_OUTREG_EN defined: a second output register SHALL be added after the array read register, giving read latency 2 cycles.
- REQ-027: Under ICACHE_BRAM_OUTREG_EN, the second register SHALL advance only when ena=1.
- REQ-028: Under ICACHE_BRAM_OUTREG_EN, rsta SHALL clear both registers asynchronously.
- REQ-029: Under ICACHE_BRAM_OUTREG_EN, in a write cycle dina SHALL appear on douta 2 cycles later.
- REQ-030: Macro ICACHE_BRAM_OUTREG_EN not defined: read latency SHALL be 1 cycle, as in REQ-013 and REQ-014.

Verification
- REQ-031: Write then read back: write 0xA5..A5 to address 5, then read address 5 -> douta=0xA5..A5 one cycle after the read edge; at the write edge itself douta=0xA5..A5 (WRITE_FIRST).
- REQ-032: Back-to-back reads: write addresses 0 and 127 with 1 and 2, then read 0,127,0 in consecutive cycles -> douta=1,2,1 on successive cycles.
- REQ-033: Enable gating: with ena=0, wea=1, address 3, dina=0xFF -> address 3 still reads 0 and douta is unchanged during the gated cycle.
- REQ-034: Asynchronous reset: with douta=0x1234, pulse rsta between clock edges -> douta=0 immediately; after release, reading the same address returns 0x1234.
- REQ-035: Tag configuration (DATA_WIDTH=20): read an unwritten address -> 0; write 0xFFFFF to address 64, then read -> 0xFFFFF.
- REQ-036: With ICACHE_BRAM_OUTREG_EN defined, repeat REQ-031 -> data appears one cycle later than without the macro.
